// File: rtl/zoom_pkg.sv
// Shared constants and FSM encoding for the zoom coordinate generator.
package zoom_pkg;

    // Fractional bits of the DDA and of the multiplier weight operand.
    localparam int ZOOM_FB  = 4;
    // Fixed-point 1.0 with ZOOM_FB fractional bits.
    localparam int ZOOM_ONE = 16;
    // Default coordinate width.
    localparam int ZOOM_CW  = 11;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } zoom_state_e;

    // Step registers are CW+FB wide; accumulators get one extra bit of headroom.
    function automatic int zoom_step_width(input int cw);
        return cw + ZOOM_FB;
    endfunction

    function automatic int zoom_acc_width(input int cw);
        return cw + ZOOM_FB + 1;
    endfunction

endpackage

// File: rtl/zoom_axis_dda.sv
// Single-axis fixed-point DDA: accumulator with saturating add, frame/line
// preset and edge clamp. Produces the coordinate of the *next* accumulator
// value so the parent can register it into its output stage.
// Optional macro ZOOM_CENTER_ALIGN_EN: preset (step-1.0)/2 for downscale steps.
module zoom_axis_dda
    import zoom_pkg::*;
#(
    parameter int CW = ZOOM_CW,
    parameter int FB = ZOOM_FB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW+FB-1:0] step_i,
    input  logic [CW-1:0] dim_i,
    input  logic          preset_i,
    input  logic          adv_i,
    output logic [CW-1:0] src_o,
    output logic [FB-1:0] frac_o,
    output logic [FB-1:0] ifrac_o
);

    localparam int SW = zoom_step_width(CW);
    localparam int AW = zoom_acc_width(CW);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] preset_val;
    logic [AW-1:0] acc_sat;
    logic [AW:0]   sum_full;
    logic [CW:0]   int_part;
    logic [CW-1:0] dim_m1;

`ifdef ZOOM_CENTER_ALIGN_EN
    localparam logic [SW-1:0] ONE_S = SW'(ZOOM_ONE);
    // Centre alignment only matters when shrinking (step above 1.0).
    assign preset_val = (step_i > ONE_S) ? {1'b0, (step_i - ONE_S) >> 1} : '0;
`else
    assign preset_val = '0;
`endif

    // Saturate at all-ones instead of wrapping back to the left edge.
    assign sum_full = {1'b0, acc_q} + {2'b00, step_i};
    assign acc_sat  = sum_full[AW] ? {AW{1'b1}} : sum_full[AW-1:0];

    // Next accumulator value: preset wins over advance, otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (preset_i) begin
            acc_d = preset_val;
        end else if (adv_i) begin
            acc_d = acc_sat;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign int_part = acc_d[AW-1:FB];
    assign dim_m1   = dim_i - CW'(1);

    // Clamp to the last source pixel; 0/1-pixel sources always give pixel 0.
    always_comb begin
        src_o  = '0;
        frac_o = '0;
        if (dim_i > CW'(1)) begin
            if (int_part >= {1'b0, dim_m1}) begin
                src_o = dim_m1;
            end else begin
                src_o  = int_part[CW-1:0];
                frac_o = acc_d[FB-1:0];
            end
        end
    end

    assign ifrac_o = ~frac_o;

endmodule

// File: rtl/zoom_coord_gen.sv
// Raster-order source coordinate and weight generator for the zoom datapath.
// Handshake: a beat is transferred on a rising edge where out_valid_o and
// out_ready_i are both high; while out_valid_o is high and out_ready_i low all
// beat outputs hold; out_valid_o never drops without a transfer except on rst.
// Optional macro ZOOM_CENTER_ALIGN_EN (in zoom_axis_dda): centre-aligned presets.
module zoom_coord_gen
    import zoom_pkg::*;
#(
    parameter int CW = ZOOM_CW,
    parameter int FB = ZOOM_FB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CW-1:0]    src_w_i,
    input  logic [CW-1:0]    src_h_i,
    input  logic [CW-1:0]    out_w_i,
    input  logic [CW-1:0]    out_h_i,
    input  logic [CW+FB-1:0] step_x_i,
    input  logic [CW+FB-1:0] step_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    src_x_o,
    output logic [CW-1:0]    src_y_o,
    output logic [FB-1:0]    frac_x_o,
    output logic [FB-1:0]    frac_y_o,
    output logic [FB-1:0]    ifrac_x_o,
    output logic [FB-1:0]    ifrac_y_o,
    output logic             sol_o,
    output logic             eol_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic [1:0]       state_dbg_o
);

    zoom_state_e state_q, state_d;

    logic [CW-1:0]    src_w_q, src_w_d, src_h_q, src_h_d;
    logic [CW-1:0]    out_w_q, out_w_d, out_h_q, out_h_d;
    logic [CW+FB-1:0] step_x_q, step_x_d, step_y_q, step_y_d;
    logic [CW-1:0]    x_q, x_d, y_q, y_d;
    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [CW-1:0]    sx_q, sx_d, sy_q, sy_d;
    logic [FB-1:0]    fx_q, fx_d, fy_q, fy_d, ifx_q, ifx_d, ify_q, ify_d;
    logic             sol_q, sol_d, eol_q, eol_d, sof_q, sof_d, eof_q, eof_d;

    logic             accept, last_x, last_px;
    logic             x_preset, x_adv, y_preset, y_adv;
    logic [CW-1:0]    nx, ny;
    logic [CW-1:0]    sx_nxt, sy_nxt;
    logic [FB-1:0]    fx_nxt, fy_nxt, ifx_nxt, ify_nxt;

    // Handshake and raster position decode for the current beat.
    assign accept  = (state_q == ST_RUN) && valid_q && out_ready_i;
    assign last_x  = (x_q == out_w_q - CW'(1));
    assign last_px = last_x && (y_q == out_h_q - CW'(1));
    assign nx      = last_x ? '0 : x_q + CW'(1);
    assign ny      = last_x ? y_q + CW'(1) : y_q;

    // Axis controls: both presets in LOAD; x restarts each line, y steps per line.
    assign x_preset = (state_q == ST_LOAD) || (accept && last_x && !last_px);
    assign x_adv    = accept && !last_x;
    assign y_preset = (state_q == ST_LOAD);
    assign y_adv    = accept && last_x && !last_px;

    zoom_axis_dda #(.CW(CW), .FB(FB)) u_dda_x (
        .clk      (clk),
        .rst      (rst),
        .step_i   (step_x_q),
        .dim_i    (src_w_q),
        .preset_i (x_preset),
        .adv_i    (x_adv),
        .src_o    (sx_nxt),
        .frac_o   (fx_nxt),
        .ifrac_o  (ifx_nxt)
    );

    zoom_axis_dda #(.CW(CW), .FB(FB)) u_dda_y (
        .clk      (clk),
        .rst      (rst),
        .step_i   (step_y_q),
        .dim_i    (src_h_q),
        .preset_i (y_preset),
        .adv_i    (y_adv),
        .src_o    (sy_nxt),
        .frac_o   (fy_nxt),
        .ifrac_o  (ify_nxt)
    );

    // Next-state and next-beat logic; everything holds unless a case updates it.
    always_comb begin
        state_d  = state_q;
        src_w_d  = src_w_q;
        src_h_d  = src_h_q;
        out_w_d  = out_w_q;
        out_h_d  = out_h_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        x_d      = x_q;
        y_d      = y_q;
        valid_d  = valid_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        ifx_d    = ifx_q;
        ify_d    = ify_q;
        sol_d    = sol_q;
        eol_d    = eol_q;
        sof_d    = sof_q;
        eof_d    = eof_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    src_w_d  = src_w_i;
                    src_h_d  = src_h_i;
                    out_w_d  = out_w_i;
                    out_h_d  = out_h_i;
                    step_x_d = step_x_i;
                    step_y_d = step_y_i;
                end
            end
            ST_LOAD: begin
                x_d = '0;
                y_d = '0;
                if ((out_w_q == '0) || (out_h_q == '0)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    sx_d    = sx_nxt;
                    sy_d    = sy_nxt;
                    fx_d    = fx_nxt;
                    fy_d    = fy_nxt;
                    ifx_d   = ifx_nxt;
                    ify_d   = ify_nxt;
                    sol_d   = 1'b1;
                    eol_d   = (out_w_q == CW'(1));
                    sof_d   = 1'b1;
                    eof_d   = (out_w_q == CW'(1)) && (out_h_q == CW'(1));
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_px) begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                    end else begin
                        x_d   = nx;
                        y_d   = ny;
                        sx_d  = sx_nxt;
                        sy_d  = sy_nxt;
                        fx_d  = fx_nxt;
                        fy_d  = fy_nxt;
                        ifx_d = ifx_nxt;
                        ify_d = ify_nxt;
                        sol_d = (nx == '0);
                        eol_d = (nx == out_w_q - CW'(1));
                        sof_d = 1'b0;
                        eof_d = (nx == out_w_q - CW'(1)) && (ny == out_h_q - CW'(1));
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State, configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_w_q  <= '0;
            src_h_q  <= '0;
            out_w_q  <= '0;
            out_h_q  <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            sx_q     <= '0;
            sy_q     <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            ifx_q    <= '0;
            ify_q    <= '0;
            sol_q    <= 1'b0;
            eol_q    <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_w_q  <= src_w_d;
            src_h_q  <= src_h_d;
            out_w_q  <= out_w_d;
            out_h_q  <= out_h_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            ifx_q    <= ifx_d;
            ify_q    <= ify_d;
            sol_q    <= sol_d;
            eol_q    <= eol_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_valid_o = valid_q;
    assign src_x_o     = sx_q;
    assign src_y_o     = sy_q;
    assign frac_x_o    = fx_q;
    assign frac_y_o    = fy_q;
    assign ifrac_x_o   = ifx_q;
    assign ifrac_y_o   = ify_q;
    assign sol_o       = sol_q;
    assign eol_o       = eol_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign state_dbg_o = state_q;

endmodule
